mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store traffic.
// Data accesses win by default; a fetch waiting too long takes over.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             if_elig;
    logic             dm_elig;
    logic             starved;
    logic             grant_dm;
    logic             grant_if;
    logic             data_fin;
    logic             fetch_fin;

    // A requester whose completion pulse is showing cannot re-win yet
    assign if_elig   = if_req & ~if_valid;
    assign dm_elig   = dm_req & ~dm_done;
    assign starved   = if_elig & (starve_cnt == CNT_MAX);
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_nxt = DATA;
                end else if (grant_if) begin
                    state_nxt = FETCH;
                end
            end
            DATA, FETCH: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        data_fin  = 1'b0;
        fetch_fin = 1'b0;
        unique case (state)
            IDLE: begin
                grant_dm = dm_elig & ~starved;
                grant_if = if_elig & ~grant_dm;
            end
            DATA: begin
                mem_en   = 1'b1;
                data_fin = mem_ready;
            end
            FETCH: begin
                mem_en    = 1'b1;
                fetch_fin = mem_ready;
            end
            default: ;
        endcase
    end

    // Command, read-data and pulse registers; command frozen until completion
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_done    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_valid <= fetch_fin;
            dm_done  <= data_fin;
            if (grant_dm) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                if (!if_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_if) begin
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                mem_wdata  <= '0;
                starve_cnt <= '0;
            end
            if (fetch_fin) begin
                if_rdata <= mem_rdata;
            end
            if (data_fin && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          stall_if;
    logic          stall_mem;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0 = none, 1 = data, 2 = fetch
    int            m_own = 0;
    int            m_cnt = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_ifr = '0;
    logic [DW-1:0] m_dmr = '0;
    logic          m_valid = 1'b0;
    logic          m_done = 1'b0;

    bit rel_if = 1'b1;
    bit rel_dm = 1'b1;
    bit mem_manual = 1'b0;
    bit rnd = 1'b0;
    int wait_n = 0;
    int en_run = 0;
    int n_en = 0;
    int n_valid = 0;
    int n_done = 0;
    int n_stall = 0;
    logic [AW-1:0] q_addr[$];
    logic          q_we[$];
    logic [DW-1:0] q_wd[$];
    logic [AW-1:0] exp_addr[6];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit de;
        bit fe;
        bit nv;
        bit nd;
        nv = 1'b0;
        nd = 1'b0;
        if (rst) begin
            m_own = 0; m_cnt = 0; m_we = 1'b0;
            m_addr = '0; m_wd = '0; m_ifr = '0; m_dmr = '0;
            m_valid = 1'b0; m_done = 1'b0;
            return;
        end
        if (m_own == 2 && mem_ready) begin
            m_ifr = mem_rdata; nv = 1'b1; m_own = 0;
        end else if (m_own == 1 && mem_ready) begin
            if (!m_we) m_dmr = mem_rdata;
            nd = 1'b1; m_own = 0;
        end else if (m_own == 0) begin
            de = dm_req && !m_done;
            fe = if_req && !m_valid;
            if (de && !(fe && m_cnt == SMAX)) begin
                m_own = 1; m_we = dm_we;
                m_addr = dm_addr; m_wd = dm_wdata;
                m_cnt = !if_req ? 0 : (m_cnt < SMAX ? m_cnt + 1 : SMAX);
            end else if (fe) begin
                m_own = 2; m_we = 1'b0;
                m_addr = if_addr; m_wd = '0; m_cnt = 0;
            end
        end
        m_valid = nv;
        m_done = nd;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("mem_en", 64'(mem_en), 64'(m_own != 0));
        chk("mem_we", 64'(mem_we), 64'(m_we));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_wd));
        chk("if_valid", 64'(if_valid), 64'(m_valid));
        chk("dm_done", 64'(dm_done), 64'(m_done));
        chk("if_rdata", 64'(if_rdata), 64'(m_ifr));
        chk("dm_rdata", 64'(dm_rdata), 64'(m_dmr));
        chk("stall_if", 64'(stall_if), 64'(if_req & ~m_valid));
        chk("stall_mem", 64'(stall_mem), 64'(dm_req & ~m_done));
        chk("starve_cnt", 64'(dut.starve_cnt), 64'(m_cnt));
        if (mem_en) begin
            en_run++;
            n_en++;
        end else begin
            en_run = 0;
        end
        if (mem_en && en_run == 1) begin
            q_addr.push_back(mem_addr);
            q_we.push_back(mem_we);
            q_wd.push_back(mem_wdata);
            if (rnd) wait_n = $urandom_range(0, 3);
        end
        if (!mem_manual) mem_ready = mem_en && (en_run > wait_n);
        if (if_valid) n_valid++;
        if (dm_done) n_done++;
        if (stall_mem) n_stall++;
        if (rel_if && if_valid) if_req = 1'b0;
        if (rel_dm && dm_done) dm_req = 1'b0;
        if (rnd) mem_rdata = $urandom;
    endtask

    task automatic clr();
        n_en = 0; n_valid = 0; n_done = 0; n_stall = 0;
        q_addr.delete(); q_we.delete(); q_wd.delete();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_dm_done", 64'(dm_done), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_dm_rdata", 64'(dm_rdata), 64'd0);
        step();
        chk("idle_no_req", 64'(mem_en), 64'd0);

        // Fetch with two wait states
        clr();
        wait_n = 2;
        mem_rdata = 32'h0050_0093;
        if_addr = 32'h100;
        if_req = 1'b1;
        repeat (8) step();
        chk("fetch_en_cycles", 64'(n_en), 64'd3);
        chk("fetch_rdata", 64'(if_rdata), 64'h0050_0093);
        chk("fetch_valid_pulses", 64'(n_valid), 64'd1);
        chk("fetch_addr", 64'(q_addr[0]), 64'h100);

        // Contention: store goes first, then the fetch
        clr();
        wait_n = 0;
        mem_rdata = 32'h1111_2222;
        if_addr = 32'h400;
        dm_we = 1'b1;
        dm_addr = 32'h2000;
        dm_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1;
        dm_req = 1'b1;
        repeat (8) step();
        chk("cont_bursts", 64'(q_addr.size()), 64'd2);
        chk("cont_first_we", 64'(q_we[0]), 64'd1);
        chk("cont_first_addr", 64'(q_addr[0]), 64'h2000);
        chk("cont_first_wdata", 64'(q_wd[0]), 64'hDEAD_BEEF);
        chk("cont_second_we", 64'(q_we[1]), 64'd0);
        chk("cont_second_addr", 64'(q_addr[1]), 64'h400);
        chk("cont_done", 64'(n_done), 64'd1);
        chk("cont_valid", 64'(n_valid), 64'd1);
        chk("store_keeps_rdata", 64'(dm_rdata), 64'd0);

        // Load with stall tracking
        clr();
        wait_n = 2;
        dm_we = 1'b0;
        dm_addr = 32'h3004;
        mem_rdata = 32'h1234_5678;
        dm_req = 1'b1;
        #1;
        chk("stall_mem_on_req", 64'(stall_mem), 64'd1);
        repeat (7) step();
        chk("load_rdata", 64'(dm_rdata), 64'h1234_5678);
        chk("load_done", 64'(n_done), 64'd1);
        chk("load_stall_cycles", 64'(n_stall), 64'd3);

        // Starvation: four data wins with fetch pending, then fetch
        clr();
        wait_n = 0;
        mem_rdata = '0;
        if_addr = 32'h600;
        for (int k = 0; k < 4; k++) begin
            dm_addr = 32'h5000 + 32'(4 * k);
            if_req = 1'b1;
            dm_req = 1'b1;
            step();
            if_req = 1'b0;
            repeat (4) step();
        end
        chk("starve_saturated", 64'(dut.starve_cnt), 64'd4);
        dm_addr = 32'h5010;
        if_req = 1'b1;
        dm_req = 1'b1;
        step();
        chk("starve_fetch_wins", 64'(mem_addr), 64'h600);
        chk("starve_cleared", 64'(dut.starve_cnt), 64'd0);
        repeat (8) step();
        exp_addr = '{32'h5000, 32'h5004, 32'h5008,
                     32'h500c, 32'h600, 32'h5010};
        chk("starve_bursts", 64'(q_addr.size()), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("starve_order%0d", k),
                64'(q_addr[k]), 64'(exp_addr[k]));
        end

        // Back-to-back request arriving in the done cycle
        clr();
        rel_dm = 1'b0;
        wait_n = 0;
        dm_we = 1'b1;
        dm_addr = 32'h7000;
        dm_wdata = 32'h1;
        dm_req = 1'b1;
        for (int i = 0; i < 10 && !dm_done; i++) step();
        chk("b2b_done_seen", 64'(dm_done), 64'd1);
        dm_addr = 32'h7004;
        dm_wdata = 32'h2;
        step();
        chk("b2b_not_granted", 64'(mem_en), 64'd0);
        step();
        chk("b2b_granted", 64'(mem_en), 64'd1);
        chk("b2b_addr", 64'(mem_addr), 64'h7004);
        rel_dm = 1'b1;
        repeat (4) step();
        chk("b2b_bursts", 64'(q_addr.size()), 64'd2);
        chk("b2b_dones", 64'(n_done), 64'd2);

        // Reset in the middle of a data access
        clr();
        wait_n = 100;
        dm_we = 1'b0;
        dm_addr = 32'h40;
        mem_rdata = 32'hCAFE_F00D;
        dm_req = 1'b1;
        repeat (3) step();
        chk("rma_busy", 64'(mem_en), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        dm_req = 1'b0;
        mem_manual = 1'b1;
        mem_ready = 1'b1;
        repeat (3) step();
        chk("rma_mem_en", 64'(mem_en), 64'd0);
        chk("rma_no_done", 64'(n_done), 64'd0);
        chk("rma_dm_rdata", 64'(dm_rdata), 64'd0);
        chk("rma_if_rdata", 64'(if_rdata), 64'd0);
        chk("rma_mem_addr", 64'(mem_addr), 64'd0);
        chk("rma_mem_we", 64'(mem_we), 64'd0);
        mem_manual = 1'b0;
        mem_ready = 1'b0;
        wait_n = 0;

        // Random traffic against the model
        clr();
        rnd = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1'b1;
                if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 3) == 0) begin
                dm_req = 1'b1;
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom;
                dm_wdata = $urandom;
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        rnd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
